// File: rtl/pix_packer_pkg.sv
// Shared PE control/config types and packing helpers for pix_packer.
// M8 packing is only available when PACK_MULT8_EN is defined.
package pix_packer_pkg;

    // PE datapath configuration
    localparam int PE_DWD   = 16;
    localparam int PE_MAXEW = 8;

    // PE control configuration
    typedef enum logic [2:0] {
        XNOR = 3'd0,
        M1   = 3'd1,
        M2   = 3'd2,
        M4   = 3'd3,
        M8   = 3'd4
    } mode_e;

    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } numt_e;

    // Control that travels with each packed word.
    typedef struct packed {
        mode_e mode;
        numt_e numt;
        logic  last;
    } word_meta_t;

    // Map a raw mode field onto the modes this build actually packs.
    function automatic mode_e norm_mode(input logic [2:0] raw);
        mode_e m;
        m = M1;
        case (raw)
            3'd0: m = XNOR;
            3'd1: m = M1;
            3'd2: m = M2;
            3'd3: m = M4;
            3'd4: begin
`ifdef PACK_MULT8_EN
                m = M8;
`else
                m = M4;
`endif
            end
            default: m = M1;
        endcase
        return m;
    endfunction

    function automatic int pack_ew(input mode_e mode);
        int ew;
        ew = 1;
        case (mode)
            M2: ew = 2;
            M4: ew = 4;
`ifdef PACK_MULT8_EN
            M8: ew = 8;
`else
            M8: ew = 4;
`endif
            default: ew = 1;
        endcase
        return ew;
    endfunction

    function automatic int pack_nl(input mode_e mode, input int dwd);
        return dwd / pack_ew(mode);
    endfunction

endpackage

// File: rtl/pack_obuf.sv
// Single-entry output register for pix_packer: loads a packed word and
// holds it stable until the downstream accepts it.
module pack_obuf
    import pix_packer_pkg::*;
#(
    parameter int DWD = PE_DWD
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [DWD-1:0]   i_pix,
    input  logic [DWD-1:0]   i_lmask,
    input  word_meta_t       i_meta,
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_free,
    output logic [DWD-1:0]   o_pix,
    output logic [DWD-1:0]   o_lmask,
    output word_meta_t       o_meta
);

    logic             valid_q, valid_d;
    logic [DWD-1:0]   pix_q, pix_d;
    logic [DWD-1:0]   lmask_q, lmask_d;
    word_meta_t       meta_q, meta_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        valid_d = valid_q & ~i_ready;
        pix_d   = pix_q;
        lmask_d = lmask_q;
        meta_d  = meta_q;
        o_free  = ~valid_q | i_ready;
        if (i_load) begin
            valid_d = 1'b1;
            pix_d   = i_pix;
            lmask_d = i_lmask;
            meta_d  = i_meta;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            pix_q   <= '0;
            lmask_q <= '0;
            meta_q  <= '{mode: M1, numt: UNSIGNED, last: 1'b0};
        end else begin
            valid_q <= valid_d;
            pix_q   <= pix_d;
            lmask_q <= lmask_d;
            meta_q  <= meta_d;
        end
    end

    assign o_valid = valid_q;
    assign o_pix   = pix_q;
    assign o_lmask = lmask_q;
    assign o_meta  = meta_q;

endmodule

// File: rtl/pix_packer.sv
// Packs narrow activation/weight elements LSB-first into DWD-bit lane words.
// Define PACK_MULT8_EN to enable M8 packing; otherwise M8 packs as M4.
module pix_packer
    import pix_packer_pkg::*;
#(
    parameter int DWD   = PE_DWD,
    parameter int MAXEW = PE_MAXEW
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [MAXEW-1:0]  i_data,
    input  logic              i_last,
    input  logic [2:0]        i_mode,
    input  logic              i_numt,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DWD-1:0]    o_pix,
    output logic [2:0]        o_mode,
    output logic              o_numt,
    output logic [DWD-1:0]    o_lmask,
    output logic              o_last
);

    localparam int CW = $clog2(DWD) + 1;

    logic [DWD-1:0]   asm_q, asm_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    mode_e            cfg_mode_q, cfg_mode_d;
    numt_e            cfg_numt_q, cfg_numt_d;

    logic             first;
    mode_e            cur_mode;
    numt_e            cur_numt;
    int               ew, nl, shamt, fill;
    logic [MAXEW-1:0] elem;
    logic [DWD-1:0]   elem_ext, merged, lmask;
    logic             closing, take, load, obuf_free;
    word_meta_t       meta, out_meta;

    always_comb begin
        asm_d      = asm_q;
        cnt_d      = cnt_q;
        cfg_mode_d = cfg_mode_q;
        cfg_numt_d = cfg_numt_q;
        load       = 1'b0;

        // Control is taken live on lane 0 and from the latched copy afterwards.
        first    = (cnt_q == '0);
        cur_mode = first ? norm_mode(i_mode) : cfg_mode_q;
        cur_numt = first ? numt_e'(i_numt) : cfg_numt_q;
        ew       = pack_ew(cur_mode);
        nl       = pack_nl(cur_mode, DWD);
        shamt    = int'(cnt_q) * ew;
        fill     = (int'(cnt_q) + 1) * ew;

        for (int i = 0; i < MAXEW; i++) begin
            elem[i] = i_data[i] & (i < ew);
        end
        elem_ext = DWD'(elem);
        merged   = asm_q | (elem_ext << shamt);
        for (int b = 0; b < DWD; b++) begin
            lmask[b] = (b < fill);
        end

        meta    = '{mode: cur_mode, numt: cur_numt, last: i_last};
        closing = ((int'(cnt_q) + 1) >= nl) | i_last;
        o_ready = ~closing | obuf_free;
        take    = i_valid & o_ready;

        if (take) begin
            if (first) begin
                cfg_mode_d = cur_mode;
                cfg_numt_d = cur_numt;
            end
            if (closing) begin
                load  = 1'b1;
                asm_d = '0;
                cnt_d = '0;
            end else begin
                asm_d = merged;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            asm_q      <= '0;
            cnt_q      <= '0;
            cfg_mode_q <= M1;
            cfg_numt_q <= UNSIGNED;
        end else begin
            asm_q      <= asm_d;
            cnt_q      <= cnt_d;
            cfg_mode_q <= cfg_mode_d;
            cfg_numt_q <= cfg_numt_d;
        end
    end

    pack_obuf #(
        .DWD (DWD)
    ) u_obuf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (load),
        .i_pix   (merged),
        .i_lmask (lmask),
        .i_meta  (meta),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_free  (obuf_free),
        .o_pix   (o_pix),
        .o_lmask (o_lmask),
        .o_meta  (out_meta)
    );

    assign o_mode = out_meta.mode;
    assign o_numt = out_meta.numt;
    assign o_last = out_meta.last;

endmodule

// File: tb/tb_pix_packer.sv
// Directed and randomized-backpressure bench for pix_packer; follows the
// PACK_MULT8_EN setting of the build for M8 expectations.
module tb_pix_packer;
    import pix_packer_pkg::*;

    localparam int DWD   = 16;
    localparam int MAXEW = 8;

    logic             i_clk;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [MAXEW-1:0] i_data;
    logic             i_last;
    logic [2:0]       i_mode;
    logic             i_numt;
    logic             o_valid;
    logic             i_ready;
    logic [DWD-1:0]   o_pix;
    logic [2:0]       o_mode;
    logic             o_numt;
    logic [DWD-1:0]   o_lmask;
    logic             o_last;

    pix_packer #(.DWD(DWD), .MAXEW(MAXEW)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .i_mode  (i_mode),
        .i_numt  (i_numt),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_pix   (o_pix),
        .o_mode  (o_mode),
        .o_numt  (o_numt),
        .o_lmask (o_lmask),
        .o_last  (o_last)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [15:0] pix;
        logic [15:0] lmask;
        logic [2:0]  mode;
        logic        numt;
        logic        last;
    } word_t;

    word_t got_q[$];
    word_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    rand_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic word_t mk(input logic [15:0] pix, input logic [15:0] lmask,
                                 input logic [2:0] mode, input logic numt, input logic last);
        word_t w;
        w.pix = pix; w.lmask = lmask; w.mode = mode; w.numt = numt; w.last = last;
        return w;
    endfunction

    // Words are captured just before the edge on which they transfer.
    always begin
        @(negedge i_clk);
        #2;
        if (!i_rst && o_valid && i_ready)
            got_q.push_back(mk(o_pix, o_lmask, o_mode, o_numt, o_last));
    end

    // Called at a negedge; returns at the negedge after the element transferred.
    task automatic send(input logic [7:0] d, input logic [2:0] m, input logic n,
                        input logic l, output int stalls);
        int guard;
        guard  = 0;
        stalls = 0;
        i_valid = 1'b1; i_data = d; i_mode = m; i_numt = n; i_last = l;
        #2;
        while (!o_ready && guard < 300) begin
            stalls++; guard++;
            @(negedge i_clk);
            #2;
        end
        if (!o_ready) check("send_timeout", o_ready, 1);
        @(negedge i_clk);
    endtask

    task automatic idle(input int cycles);
        i_valid = 1'b0; i_last = 1'b0;
        repeat (cycles) @(negedge i_clk);
    endtask

    task automatic expect_word(input string tag, input word_t exp);
        int    guard;
        word_t w;
        guard = 0;
        while (got_q.size() == 0 && guard < 60) begin
            @(negedge i_clk);
            guard++;
        end
        if (got_q.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            w = got_q.pop_front();
            check({tag, "_pix"},   w.pix,   exp.pix);
            check({tag, "_lmask"}, w.lmask, exp.lmask);
            check({tag, "_mode"},  w.mode,  exp.mode);
            check({tag, "_numt"},  w.numt,  exp.numt);
            check({tag, "_last"},  w.last,  exp.last);
        end
    endtask

    initial begin
        int st, stall_early, stall_last, unstable, guard;
        int total, m, em, ew, nl, n, pix, lm, d;
        logic lastflag, nt;

        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0;
        i_mode = 3'd0; i_numt = 1'b0; i_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        #2;
        check("rst_valid", o_valid, 0);
        check("rst_pix",   o_pix,   0);
        check("rst_lmask", o_lmask, 0);
        check("rst_mode",  o_mode,  M1);
        check("rst_numt",  o_numt,  UNSIGNED);
        check("rst_last",  o_last,  0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #2;
        check("rst_ready", o_ready, 1);
        @(negedge i_clk);

        // M4 full word, back to back
        send(8'h1, M4, SIGNED, 1'b0, st);
        send(8'h2, M4, SIGNED, 1'b0, st);
        send(8'h3, M4, SIGNED, 1'b0, st);
        check("t1_not_early", o_valid, 0);
        send(8'h4, M4, SIGNED, 1'b0, st);
        check("t1_latency", o_valid, 1);
        idle(1);
        expect_word("t1", mk(16'h4321, 16'hFFFF, M4, SIGNED, 1'b0));

        // M2 partial word closed by i_last
        send(8'h3, M2, UNSIGNED, 1'b0, st);
        send(8'h1, M2, UNSIGNED, 1'b0, st);
        send(8'h2, M2, UNSIGNED, 1'b1, st);
        idle(2);
        expect_word("t2", mk(16'h0027, 16'h003F, M2, UNSIGNED, 1'b1));
        idle(2);

        // M1 with the first word held by downstream backpressure
        stall_early = 0; stall_last = 0; unstable = 0;
        i_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 32; k++) begin
                    send((k % 2 == 0) ? 8'h1 : 8'h0, M1, UNSIGNED, 1'b0, st);
                    if (k < 31) stall_early += st;
                    else        stall_last = st;
                end
                idle(1);
            end
            begin
                guard = 0;
                while (!o_valid && guard < 100) begin
                    @(negedge i_clk); #2; guard++;
                end
                repeat (18) begin
                    @(negedge i_clk); #2;
                    if (!o_valid || o_pix !== 16'h5555) unstable++;
                end
                @(negedge i_clk);
                i_ready = 1'b1;
            end
        join
        check("t3_hold_stable", unstable, 0);
        check("t3_no_early_stall", stall_early, 0);
        check("t3_close_stalled", (stall_last > 0), 1);
        expect_word("t3a", mk(16'h5555, 16'hFFFF, M1, UNSIGNED, 1'b0));
        expect_word("t3b", mk(16'h5555, 16'hFFFF, M1, UNSIGNED, 1'b0));
        idle(2);

        // Mode change mid-word is ignored until the word closes
        send(8'h01, M2, SIGNED, 1'b0, st);
        send(8'h02, M2, SIGNED, 1'b0, st);
        send(8'h03, M2, SIGNED, 1'b0, st);
        send(8'hFD, M8, UNSIGNED, 1'b0, st);
        send(8'h02, M8, UNSIGNED, 1'b0, st);
        send(8'h03, M8, UNSIGNED, 1'b0, st);
        send(8'h00, M8, UNSIGNED, 1'b0, st);
        send(8'h01, M8, UNSIGNED, 1'b0, st);
        send(8'hAB, M8, UNSIGNED, 1'b0, st);
        send(8'hCD, M8, UNSIGNED, 1'b0, st);
        send(8'h12, M8, UNSIGNED, 1'b0, st);
        send(8'h34, M8, UNSIGNED, 1'b0, st);
        idle(2);
        expect_word("t4_m2", mk(16'h4E79, 16'hFFFF, M2, SIGNED, 1'b0));
`ifdef PACK_MULT8_EN
        expect_word("t4_m8a", mk(16'hCDAB, 16'hFFFF, M8, UNSIGNED, 1'b0));
        expect_word("t4_m8b", mk(16'h3412, 16'hFFFF, M8, UNSIGNED, 1'b0));
`else
        expect_word("t4_m4", mk(16'h42DB, 16'hFFFF, M4, UNSIGNED, 1'b0));
`endif

        // One-lane words: i_last on lane 0, illegal mode, M8 single element
        send(8'h19, M4, SIGNED, 1'b1, st);
        send(8'hFF, 3'd7, UNSIGNED, 1'b1, st);
        send(8'hAB, M8, SIGNED, 1'b1, st);
        idle(2);
        expect_word("t5_m4_one", mk(16'h0009, 16'h000F, M4, SIGNED, 1'b1));
        expect_word("t5_illegal", mk(16'h0001, 16'h0001, M1, UNSIGNED, 1'b1));
`ifdef PACK_MULT8_EN
        expect_word("t5_m8_one", mk(16'h00AB, 16'h00FF, M8, SIGNED, 1'b1));
`else
        expect_word("t5_m8_one", mk(16'h000B, 16'h000F, M4, SIGNED, 1'b1));
`endif
        idle(2);

        // Async reset with a held word and a partial word in flight
        i_ready = 1'b0;
        send(8'h1, M4, SIGNED, 1'b0, st);
        send(8'h2, M4, SIGNED, 1'b0, st);
        send(8'h3, M4, SIGNED, 1'b0, st);
        send(8'h4, M4, SIGNED, 1'b0, st);
        send(8'h7, M4, SIGNED, 1'b0, st);
        send(8'h8, M4, SIGNED, 1'b0, st);
        i_valid = 1'b0;
        check("t6_held_before_rst", o_valid, 1);
        #1 i_rst = 1'b1;
        #1;
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_pix",   o_pix,   0);
        check("t6_rst_lmask", o_lmask, 0);
        check("t6_rst_mode",  o_mode,  M1);
        check("t6_rst_numt",  o_numt,  UNSIGNED);
        check("t6_rst_last",  o_last,  0);
        #2 i_rst = 1'b0;
        @(negedge i_clk);
        i_ready = 1'b1;
        check("t6_no_stale_word", got_q.size(), 0);
        send(8'h5, M4, UNSIGNED, 1'b0, st);
        send(8'h6, M4, UNSIGNED, 1'b0, st);
        send(8'h7, M4, UNSIGNED, 1'b0, st);
        send(8'h8, M4, UNSIGNED, 1'b0, st);
        idle(2);
        expect_word("t6_clean", mk(16'h8765, 16'hFFFF, M4, UNSIGNED, 1'b0));
        idle(2);

        // Mixed modes under random valid/ready backpressure
        total = 0;
        fork
            begin
                while (total < 1000) begin
                    m = $urandom_range(0, 7);
                    case (m)
                        0: begin em = XNOR; ew = 1; end
                        2: begin em = M2;   ew = 2; end
                        3: begin em = M4;   ew = 4; end
`ifdef PACK_MULT8_EN
                        4: begin em = M8;   ew = 8; end
`else
                        4: begin em = M4;   ew = 4; end
`endif
                        default: begin em = M1; ew = 1; end
                    endcase
                    nl = 16 / ew;
                    n  = ($urandom_range(0, 1) == 1) ? nl : $urandom_range(1, nl);
                    lastflag = (n < nl) ? 1'b1 : 1'($urandom_range(0, 1));
                    nt  = 1'($urandom_range(0, 1));
                    pix = 0;
                    lm  = (1 << (n * ew)) - 1;
                    for (int i = 0; i < n; i++) begin
                        d = $urandom_range(0, 255);
                        pix |= (d & ((1 << ew) - 1)) << (i * ew);
                        if (i == 0)
                            send(8'(d), 3'(m), nt, (n == 1) && lastflag, st);
                        else
                            send(8'(d), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                                 (i == n - 1) && lastflag, st);
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    end
                    exp_q.push_back(mk(16'(pix), 16'(lm), 3'(em), nt, lastflag));
                    total += n;
                end
                idle(1);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge i_clk);
                    i_ready = ($urandom_range(0, 2) != 0);
                end
                i_ready = 1'b1;
            end
        join
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        idle(4);
        check("rand_word_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check("rand_word", got_q.pop_front(), exp_q.pop_front());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
